// File: rtl/pal_pkg.sv
// pal_pkg: shared PAL config constants, loader state encoding and CRC-8 helpers
package pal_pkg;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, APPLY} ld_state_e;
    function automatic int cfg_len(input int n, input int p, input int m);
        return 2 * n * p + p * m;
    endfunction
    // MSB-first CRC-8, no reflection, no final XOR
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        return c;
    endfunction
endpackage

// File: rtl/pal_cfg_crc8.sv
// pal_cfg_crc8: byte-wide combinational CRC-8 step
module pal_cfg_crc8 (
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);
    import pal_pkg::*;
    assign crc_next = crc8_byte(crc, data);
endmodule

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: streams a byte frame LSB-first into the PAL cfg chain, checks CRC-8, pulses apply
module pal_cfg_loader #(
    parameter int N            = 8,
    parameter int P            = 17,
    parameter int M            = 6,
    parameter int CHECK_CRC    = 1,
    parameter int APPLY_CYCLES = 2
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       cfg_bit,
    output logic       cfg_shift,
    output logic       cfg_en,
    output logic       busy,
    output logic       done,
    output logic       crc_err
);
    import pal_pkg::*;
    localparam int CFG_BITS  = cfg_len(N, P, M);
    localparam int NBYTES    = (CFG_BITS + 7) / 8;
    localparam int LAST_BITS = CFG_BITS - 8 * (NBYTES - 1);
    localparam int BW        = $clog2(NBYTES + 1);
    ld_state_e state, state_n;
    logic [BW-1:0] byte_cnt;
    logic [3:0] bits_left, apply_cnt;
    logic [7:0] sreg, crc, crc_next;
    logic hs, last_byte, last_bit;
    logic s_ready_d, cfg_bit_d, cfg_shift_d, cfg_en_d, busy_d, done_d;
    assign hs        = s_valid && s_ready;
    assign last_byte = byte_cnt == BW'(NBYTES - 1);
    assign last_bit  = bits_left == 4'd1;
    pal_cfg_crc8 u_crc (.crc(crc), .data(s_data), .crc_next(crc_next));
    always_ff @(posedge clk) state <= res ? IDLE : state_n;
    always_comb begin
        state_n = state;
        if (abort) state_n = IDLE;
        else case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    if (hs) state_n = SHIFT;
            SHIFT:   if (last_bit) state_n = !last_byte ? LOAD : (CHECK_CRC != 0 ? CHECK : APPLY);
            CHECK:   if (hs) state_n = s_data == crc ? APPLY : IDLE;
            APPLY:   if (apply_cnt == 4'(APPLY_CYCLES - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so the registered copies track the state register exactly
    always_comb begin
        s_ready_d   = state_n == LOAD || state_n == CHECK;
        cfg_shift_d = state_n == SHIFT;
        cfg_bit_d   = state_n == SHIFT && (state == SHIFT ? sreg[1] : s_data[0]);
        cfg_en_d    = state_n == APPLY;
        busy_d      = state_n != IDLE;
        done_d      = state == APPLY && state_n == IDLE && !abort;
    end
    always_ff @(posedge clk) begin
        if (res) begin
            {s_ready, cfg_bit, cfg_shift, cfg_en, busy, done} <= '0;
        end else begin
            {s_ready, cfg_bit, cfg_shift, cfg_en, busy, done} <=
                {s_ready_d, cfg_bit_d, cfg_shift_d, cfg_en_d, busy_d, done_d};
        end
    end
    always_ff @(posedge clk) begin
        if (res) begin
            byte_cnt  <= '0;
            bits_left <= '0;
            apply_cnt <= '0;
            sreg      <= '0;
            crc       <= '0;
            crc_err   <= 1'b0;
        end else begin
            if (state == IDLE && start && !abort) begin
                crc      <= '0;
                byte_cnt <= '0;
                crc_err  <= 1'b0;
            end
            if (state == LOAD && hs) begin
                sreg      <= s_data;
                crc       <= crc_next;
                bits_left <= last_byte ? 4'(LAST_BITS) : 4'd8;
            end
            if (state == SHIFT) begin
                sreg      <= sreg >> 1;
                bits_left <= bits_left - 4'd1;
                if (last_bit) byte_cnt <= byte_cnt + BW'(1);
            end
            if (state == CHECK && hs && s_data != crc && !abort) crc_err <= 1'b1;
            apply_cnt <= state == APPLY ? apply_cnt + 4'd1 : 4'd0;
        end
    end
endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb_pal_cfg_loader: randomized scoreboard bench for pal_cfg_loader (N=2, P=2, M=1)
module tb_pal_cfg_loader;
    logic clk = 1'b0, res = 1'b1, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic s_ready, cfg_bit, cfg_shift, cfg_en, busy, done, crc_err;
    int checks = 0, failures = 0;
    bit bit_q[$];
    int en_q[$];
    bit out_q[$];
    int en_run = 0;
    bit en_prev = 1'b0, err_prev = 1'b0;

    always #5 clk = ~clk;

    pal_cfg_loader #(.N(2), .P(2), .M(1), .CHECK_CRC(1), .APPLY_CYCLES(2)) dut (
        .clk(clk), .res(res), .start(start), .abort(abort), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .cfg_bit(cfg_bit), .cfg_shift(cfg_shift), .cfg_en(cfg_en),
        .busy(busy), .done(done), .crc_err(crc_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame CRC as polynomial division over the 16-bit message stream
    function automatic logic [7:0] ref_crc(input logic [15:0] msg);
        logic [7:0] c = 8'h00;
        for (int i = 15; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ msg[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    always @(negedge clk) if (!res) begin
        if (cfg_shift) begin
            chk("shift_expected", 32'(bit_q.size() > 0), 1);
            if (bit_q.size() > 0) chk("cfg_bit", cfg_bit, bit_q.pop_front());
            chk("ready_in_shift", s_ready, 0);
        end
        if (cfg_en) en_run++;
        else if (en_prev) begin
            chk("cfg_en_expected", 32'(en_q.size() > 0), 1);
            if (en_q.size() > 0) chk("cfg_en_len", en_run, en_q.pop_front());
            en_run = 0;
        end
        en_prev = cfg_en;
        if (done) begin
            chk("done_expected", 32'(out_q.size() > 0), 1);
            if (out_q.size() > 0) chk("outcome_done", 1, out_q.pop_front());
            chk("done_crc_err", crc_err, 0);
        end
        if (crc_err && !err_prev) begin
            chk("err_expected", 32'(out_q.size() > 0), 1);
            if (out_q.size() > 0) chk("outcome_err", 0, out_q.pop_front());
        end
        err_prev = crc_err;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data = b;
        do begin @(negedge clk); t++; end while (!s_ready && t < 100);
        if (!s_ready) chk("ready_timeout", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end while (busy && t < 300);
        chk("idle_reached", busy, 0);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_cfg_shift"}, cfg_shift, 0);
        chk({tag, "_cfg_en"}, cfg_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] crc_b,
                         input int gap, input bit poke, input bit res_apply);
        bit good = crc_b == ref_crc({d0, d1});
        int t = 0;
        for (int i = 0; i < 8; i++) bit_q.push_back(d0[i]);
        for (int i = 0; i < 2; i++) bit_q.push_back(d1[i]);
        if (good) en_q.push_back(res_apply ? 1 : 2);
        if (!res_apply) out_q.push_back(good);
        pulse_start();
        send(d0, gap);
        if (poke) pulse_start();
        send(d1, gap);
        send(crc_b, gap);
        if (res_apply) begin
            do begin @(negedge clk); t++; end while (!cfg_en && t < 20);
            chk("apply_seen", cfg_en, 1);
            #1 res = 1'b1;
            @(posedge clk); #1;
            res = 1'b0;
            @(negedge clk);
            outputs_zero("res_apply");
            chk("res_apply_crc_err", crc_err, 0);
            @(posedge clk); #1;
        end else begin
            wait_idle();
            chk("frame_crc_err", crc_err, 32'(!good));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] a, b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outputs_zero("reset");
        chk("reset_crc_err", crc_err, 0);
        chk("reset_cfg_bit", cfg_bit, 0);
        @(posedge clk); #1;
        res = 1'b0;
        frame(8'h01, 8'h00, 8'h15, 0, 1'b0, 1'b0);
        frame(8'h01, 8'h00, 8'h14, 0, 1'b0, 1'b0);
        frame(8'h01, 8'h00, 8'h15, 12, 1'b0, 1'b0);
        // abort on the 4th shift strobe of byte 0
        for (int i = 0; i < 4; i++) bit_q.push_back(a[i] ^ a[i] ^ (i == 1));
        pulse_start();
        send(8'h02, 0);
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        outputs_zero("abort");
        @(posedge clk); #1;
        frame(8'hA5, 8'h3C, ref_crc(16'hA53C), 3, 1'b0, 1'b0);
        frame(8'h5A, 8'h81, ref_crc(16'h5A81), 0, 1'b1, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        outputs_zero("start_abort");
        @(posedge clk); #1;
        frame(8'hC3, 8'h02, ref_crc(16'hC302), 0, 1'b0, 1'b1);
        frame(8'h77, 8'h01, ref_crc(16'h7701) ^ 8'h40, 0, 1'b0, 1'b0);
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        repeat (3) begin
            @(negedge clk);
            outputs_zero("res_err");
            chk("res_err_crc_err", crc_err, 0);
        end
        @(posedge clk); #1;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            frame(a, b, ($urandom_range(0, 3) != 0) ? ref_crc({a, b}) : ref_crc({a, b}) ^ 8'($urandom_range(1, 255)),
                  $urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'b0);
        end
        repeat (5) @(posedge clk);
        chk("bit_q_empty", bit_q.size(), 0);
        chk("en_q_empty", en_q.size(), 0);
        chk("out_q_empty", out_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
